// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry byte-writable register bank.
// The REGFILE_R0_ZERO_EN macro (consumed in regfile_wr32) hardwires register 0 to zero.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NREGS      = 2 ** ADDR_W_DEF;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/regfile_wr32_wr_dec.sv
// Write-address decoder: turns an accepted write into a one-hot per-register strobe.
module wr_dec #(
   parameter int ADDR_W = 5,
   parameter int NR     = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              fire,
   output logic [NR-1:0]     wr_stb
);

   always_comb begin
      wr_stb = '0;
      if (fire) begin
         wr_stb[wr_addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wr32.sv
// Byte-enabled register bank with a one-register-per-cycle clear sweep.
// Define REGFILE_R0_ZERO_EN to make register 0 read as zero and discard writes to it.
module regfile_wr32
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic [DATA_W/8-1:0]            wr_be,
   input  logic                           clr_req,
   output logic                           busy,
   output logic                           clr_done,
   output logic [DATA_W*(2**ADDR_W)-1:0]  regs_out
);

   localparam int NR    = 2 ** ADDR_W;
   localparam int BYTES = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NR - 1);

`ifdef REGFILE_R0_ZERO_EN
   localparam logic [NR-1:0] WR_MASK = {{(NR-1){1'b1}}, 1'b0};
`else
   localparam logic [NR-1:0] WR_MASK = {NR{1'b1}};
`endif

   state_t             state;
   state_t             next_state;
   logic [ADDR_W-1:0]  idx;
   logic               fire;
   logic [NR-1:0]      wr_stb;
   logic [NR-1:0]      wr_en;
   logic [DATA_W-1:0]  regs [NR];

   assign fire  = wr_valid & wr_ready;
   assign wr_en = wr_stb & WR_MASK;

   wr_dec #(
      .ADDR_W (ADDR_W),
      .NR     (NR)
   ) u_wr_dec (
      .wr_addr (wr_addr),
      .fire    (fire),
      .wr_stb  (wr_stb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (clr_req) next_state = CLEAR;
         CLEAR:   if (idx == LAST_IDX) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      wr_ready = (state == IDLE);
      busy     = (state == CLEAR);
      clr_done = (state == CLEAR) && (idx == LAST_IDX);
   end

   // Held at 0 while idle so every sweep starts from register 0.
   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         idx <= '0;
      end else begin
         idx <= idx + 1'b1;
      end
   end

   for (genvar k = 0; k < NR; k++) begin : g_reg
      always_ff @(posedge clk) begin
         if (reset) begin
            regs[k] <= '0;
         end else if (busy && idx == ADDR_W'(k)) begin
            regs[k] <= '0;
         end else if (wr_en[k]) begin
            for (int b = 0; b < BYTES; b++) begin
               if (wr_be[b]) begin
                  regs[k][b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
      end

      assign regs_out[k*DATA_W +: DATA_W] = regs[k];
   end

endmodule

// File: tb/tb_regfile_wr32.sv
// Scoreboard bench for regfile_wr32: expected register values are queued at drive time and popped after the write edge.
module tb_regfile_wr32;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   typedef struct {
      int          addr;
      logic [31:0] val;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               wr_valid;
   logic               wr_ready;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic [DW/8-1:0]    wr_be;
   logic               clr_req;
   logic               busy;
   logic               clr_done;
   logic [DW*NR-1:0]   regs_out;

   logic [31:0] model [NR];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   regfile_wr32 #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .regs_out (regs_out)
   );

   always #5 clk = ~clk;

   function automatic logic [DW*NR-1:0] model_flat();
      logic [DW*NR-1:0] v;
      for (int k = 0; k < NR; k++) v[k*DW +: DW] = model[k];
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
`ifdef REGFILE_R0_ZERO_EN
      if (a != 0) model[a] = merge(model[a], d, be);
`else
      model[a] = merge(model[a], d, be);
`endif
      exp_q.push_back('{a, model[a]});
   endtask

   task automatic model_clear();
      for (int k = 0; k < NR; k++) model[k] = '0;
   endtask

   // Drives one write for a single edge and leaves the bench #1 after that edge.
   task automatic drive_write(input int a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = AW'(a);
      wr_data  = d;
      wr_be    = be;
      model_write(a, d, be);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_be    = '0;
   endtask

   task automatic test_reset();
      exp_t e;
      reset    = 1'b1;
      wr_valid = 1'b1;
      wr_addr  = 5'd3;
      wr_data  = 32'hCAFEF00D;
      wr_be    = 4'hF;
      clr_req  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_clear();
      checks++;
      if (regs_out !== model_flat()) begin
         errors++;
         $display("[TB] FAIL reset_regs got %h expected all zero", regs_out);
      end
      checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b0 || clr_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got ready=%b busy=%b done=%b expected 1/0/0",
                  wr_ready, busy, clr_done);
      end
      @(negedge clk);
      reset    = 1'b0;
      wr_valid = 1'b0;
      wr_be    = '0;
      clr_req  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle got ready=%b busy=%b expected 1/0", wr_ready, busy);
      end
      exp_q.delete();
      e = '{0, 32'h0};
      checks++;
      if (regs_out[e.addr*DW +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL post_reset_r0 got %h expected %h", regs_out[e.addr*DW +: DW], e.val);
      end
   endtask

   task automatic test_byte_write();
      exp_t e;
      drive_write(5, 32'hDEADBEEF, 4'hF);
      e = exp_q.pop_front();
      checks++;
      if (regs_out[e.addr*DW +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL full_write reg%0d got %h expected %h", e.addr,
                  regs_out[e.addr*DW +: DW], e.val);
      end
      checks++;
      if (regs_out !== model_flat()) begin
         errors++;
         $display("[TB] FAIL others_zero got %h expected %h", regs_out, model_flat());
      end
      drive_write(5, 32'h11223344, 4'h5);
      e = exp_q.pop_front();
      checks++;
      if (regs_out[e.addr*DW +: DW] !== 32'hDE22BE44 || e.val !== 32'hDE22BE44) begin
         errors++;
         $display("[TB] FAIL partial_write reg5 got %h expected %h", regs_out[5*DW +: DW],
                  32'hDE22BE44);
      end
      drive_write(5, 32'h00000000, 4'h0);
      e = exp_q.pop_front();
      checks++;
      if (regs_out !== model_flat() || regs_out[e.addr*DW +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL zero_be got reg5=%h expected %h", regs_out[5*DW +: DW], e.val);
      end
      drive_write(9, 32'hA0B1C2D3, 4'hA);
      e = exp_q.pop_front();
      checks++;
      if (regs_out[e.addr*DW +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL be_a reg9 got %h expected %h", regs_out[9*DW +: DW], e.val);
      end
   endtask

   task automatic test_r0();
      exp_t e;
      drive_write(0, 32'h12345678, 4'hF);
      e = exp_q.pop_front();
      checks++;
      if (regs_out[0 +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL reg0_write got %h expected %h", regs_out[0 +: DW], e.val);
      end
   endtask

   // Counts sweep cycles from the current point; leaves bench #1 after the edge that returns to IDLE.
   task automatic watch_sweep(input int mid_req_cycle, output int n, output int done_at,
                              output int done_cnt);
      n        = 0;
      done_at  = -1;
      done_cnt = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (!busy) break;
         n++;
         if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_in_sweep cycle %0d got %b expected 0", n, wr_ready);
         end
         if (clr_done) begin
            done_cnt++;
            done_at = n;
         end
         @(negedge clk);
         clr_req = (n == mid_req_cycle);
         @(posedge clk);
         #1;
      end
      clr_req = 1'b0;
   endtask

   task automatic test_clear();
      exp_t e;
      int   n, done_at, done_cnt, bad;
      bad = 0;
      for (int k = 0; k < NR; k++) begin
         drive_write(k, 32'hFFFFFFFF, 4'hF);
         e = exp_q.pop_front();
         if (regs_out[e.addr*DW +: DW] !== e.val) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL fill %0d registers wrong, expected 0", bad);
      end
      @(negedge clk);
      clr_req = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      watch_sweep(-1, n, done_at, done_cnt);
      checks++;
      if (n != 32 || done_at != 32 || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL sweep_len got cycles=%0d done_at=%0d pulses=%0d expected 32/32/1",
                  n, done_at, done_cnt);
      end
      checks++;
      if (regs_out !== model_flat() || wr_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_sweep got ready=%b busy=%b regs=%h expected idle, zero",
                  wr_ready, busy, regs_out);
      end
   endtask

   task automatic test_write_and_clear();
      exp_t e;
      int   n, done_at, done_cnt;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = 5'd7;
      wr_data  = 32'hA5A5A5A5;
      wr_be    = 4'hF;
      clr_req  = 1'b1;
      model_write(7, 32'hA5A5A5A5, 4'hF);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_be    = '0;
      clr_req  = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (regs_out[e.addr*DW +: DW] !== e.val || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_with_clr reg7 got %h busy=%b expected %h busy=1",
                  regs_out[7*DW +: DW], busy, e.val);
      end
      model_clear();
      watch_sweep(10, n, done_at, done_cnt);
      checks++;
      if (n != 32 || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL mid_sweep_req got cycles=%0d pulses=%0d expected 32/1", n, done_cnt);
      end
      checks++;
      if (regs_out !== model_flat()) begin
         errors++;
         $display("[TB] FAIL reg7_zeroed got %h expected %h", regs_out[7*DW +: DW], model[7]);
      end
   endtask

   task automatic test_reset_mid_sweep();
      exp_t e;
      int   pulses;
      pulses = 0;
      drive_write(31, 32'h0BADF00D, 4'hF);
      e = exp_q.pop_front();
      checks++;
      if (regs_out[e.addr*DW +: DW] !== e.val) begin
         errors++;
         $display("[TB] FAIL pre_abort reg31 got %h expected %h", regs_out[31*DW +: DW], e.val);
      end
      @(negedge clk);
      clr_req = 1'b1;
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      for (int cyc = 1; cyc < 10; cyc++) begin
         if (clr_done) pulses++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (clr_done || busy) pulses++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done got %0d done/busy cycles expected 0", pulses);
      end
      checks++;
      if (regs_out !== model_flat() || wr_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_state got ready=%b reg31=%h expected 1/0", wr_ready,
                  regs_out[31*DW +: DW]);
      end
   endtask

   initial begin
      for (int k = 0; k < NR; k++) model[k] = '0;
      reset    = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      wr_be    = '0;
      clr_req  = 1'b0;
      test_reset();
      test_byte_write();
      test_r0();
      test_clear();
      test_write_and_clear();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr32.md
REGFILE_WR32 -- requirements
Module: regfile_wr32

Interface
REQ-001 Parameters SHALL be exactly the two below.
REQ-002 DATA_W, 32, register width in bits; must be a multiple of 8.
REQ-003 ADDR_W, 5, write-address width; register count is 2**ADDR_W.
REQ-004 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_valid  in  1  write request present.
REQ-008 wr_ready  out  1  write can be accepted this cycle.
REQ-009 wr_addr  in  ADDR_W  target register index.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 wr_be  in  DATA_W/8  byte enables; bit i covers data bits 8i+7:8i.
REQ-012 clr_req  in  1  request a full-bank clear sweep.
REQ-013 busy  out  1  clear sweep in progress.
REQ-014 clr_done  out  1  one-cycle pulse on the final sweep write.
REQ-015 regs_out  out  DATA_W*2**ADDR_W  flattened bank; register k at bits k*DATA_W+DATA_W-1:k*DATA_W, feeding the read-side 32:1 mux.

Function
REQ-016 The write handshake SHALL fire when wr_valid and wr_ready are both 1 at a rising edge.
REQ-017 On handshake, only bytes with wr_be set SHALL update; the other bytes SHALL hold.
REQ-018 Write latency SHALL be 1: new data is visible on regs_out in the cycle after the handshake edge.
REQ-019 wr_be all-zero with a handshake SHALL consume the request and change no register.
REQ-020 The FSM SHALL have two states: IDLE (wr_ready=1, busy=0) and CLEAR (wr_ready=0, busy=1).
REQ-021 IDLE SHALL move to CLEAR when clr_req=1; the sweep index SHALL be loaded to 0.
REQ-022 In CLEAR, register[index] SHALL be written 0 and the index incremented each cycle.
REQ-023 Index 2**ADDR_W-1 SHALL be cleared, assert clr_done for that cycle, and return to IDLE, giving 32 CLEAR cycles at default.
REQ-024 A write and clr_req in the same IDLE cycle SHALL both take effect: the write lands at that edge, and the sweep starts next cycle and zeroes it.
REQ-025 clr_req while in CLEAR SHALL be ignored; it does not restart or extend the sweep.
REQ-026 wr_ready SHALL depend only on state, never combinationally on wr_valid.

Reset
REQ-027 reset=1 at an edge SHALL zero all registers, enter IDLE, and zero the sweep index.
REQ-028 Reset outputs SHALL be: regs_out=0, wr_ready=1 (from the cycle after reset), busy=0, clr_done=0.
REQ-029 Reset SHALL override any concurrent handshake or clr_req; reset mid-sweep SHALL abort with no clr_done.

Configuration
REQ-030 Macro REGFILE_R0_ZERO_EN SHALL control register 0.
REQ-031 With REGFILE_R0_ZERO_EN defined, register 0 SHALL read 0 at all times; writes to it complete the handshake but are discarded.
REQ-032 Without REGFILE_R0_ZERO_EN, register 0 SHALL be an ordinary writable register.

Structure
REQ-033 Shared package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, NREGS, and the state enum {IDLE, CLEAR}.
REQ-034 Sub-module wr_dec SHALL decode wr_addr plus handshake into a one-hot per-register write strobe.

Verification
REQ-035 Reset, then write addr 5, data 0xDEADBEEF, be 0xF -> reg5=0xDEADBEEF next cycle; all other registers 0.
REQ-036 reg5=0xDEADBEEF, write addr 5, data 0x11223344, be 0x5 -> reg5=0xDE22BE44.
REQ-037 Fill all registers with 0xFFFFFFFF, pulse clr_req -> busy=1 and wr_ready=0 for 32 cycles, clr_done on cycle 32, all registers 0, then IDLE.
REQ-038 Write addr 7 plus clr_req in the same cycle -> reg7 briefly holds the data, then is zeroed by the sweep; a second clr_req mid-sweep -> sweep still lasts 32 cycles.
REQ-039 Assert reset at sweep cycle 10 -> all registers 0, IDLE, no clr_done pulse.
REQ-040 Write addr 0, data 0x12345678 -> reg0=0 with REGFILE_R0_ZERO_EN defined; reg0=0x12345678 without it.
